priority_decoder_hold: RTL and testbench
========================================

// Module: priority_decoder_hold
// PURPOSE
//  Receive side of the 4-bit priority encoder link: accepts a 2-bit index (plus zero flag) over
//  a valid/ready handshake and drives the matching one-hot line for a programmable hold time.
//  Sits downstream of the priority encoder and drives per-line enables/grants in the datapath.
//  Also keeps a saturating count of accepted decodes for debug.
// PARAMETERS
//  IN_W         2   width of encoded index; OUT_W = 1<<IN_W is derived (localparam, 4 by default)
//  HOLD_CYCLES  4   cycles each one-hot result stays on out_onehot (legal range 1..255)
//  CNT_W        8   width of decode_count
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  in_valid      in   1       in_code/in_zero valid this cycle
//  in_ready      out  1       block can accept a code this cycle
//  in_code       in   IN_W    encoded index (11 = bit 3 highest priority)
//  in_zero       in   1       source vector was all-zero; decode to no line set
//  out_onehot    out  OUT_W   decoded one-hot line, held HOLD_CYCLES
//  out_valid     out  1       out_onehot carries a live decode
//  busy          out  1       FSM in HOLD
//  decode_count  out  CNT_W   accepted transactions, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, out_onehot=0, out_valid=0, busy=0, hold counter=0,
//    decode_count=0; takes effect immediately, including mid-HOLD (output drops that instant).
//  - Accept = in_valid & in_ready, sampled at rising clk.
//  - FSM states: IDLE, HOLD.
//    IDLE: in_ready=1. On accept -> HOLD; next cycle out_valid=1,
//      out_onehot = in_zero ? 0 : (1 << in_code); hold counter <= HOLD_CYCLES-1.
//    HOLD: busy=1; out_onehot/out_valid frozen; counter decrements each cycle.
//      in_ready = (counter==0) (combinational from registered counter).
//      counter==0 & accept  -> stay HOLD, load new decode, counter <= HOLD_CYCLES-1 (back-to-back,
//        out_valid never drops).
//      counter==0 & !accept -> IDLE; next cycle out_onehot=0, out_valid=0.
//  - Latency: accept at edge N -> out_onehot valid after edge N, for exactly HOLD_CYCLES cycles.
//  - HOLD_CYCLES=1: counter loads 0, in_ready stays 1 in HOLD; one decode per cycle sustained.
//  - in_code/in_zero ignored when not accepted (in_valid=0 or in_ready=0); no buffering,
//    source must hold in_valid until in_ready.
//  - in_zero=1 overrides in_code; out_valid=1 with out_onehot=0 (still a counted transaction).
//  - decode_count +1 per accept, saturates at 2^CNT_W-1 (no wrap).
//  - out_onehot is always 0 or exactly one bit set (one-hot-or-zero invariant).
// STRUCTURE
//  - Shared package/header prio_codec_pkg: IN_W/OUT_W defaults, FSM state encodings
//    (IDLE=1'b0, HOLD=1'b1), ZERO_CODE convention; shared with the priority encoder side.
//  - One sub-module: hold_timer (load/decrement down-counter, done = count==0).
//  - Decode logic and saturating counter inline in top module.
// TESTING
//  - Reset: rst_n=0 any time -> out_onehot=0000, out_valid=0, in_ready=1, decode_count=0 same cycle.
//  - Single decode: in_code=10,in_zero=0, HOLD=4 -> out_onehot=0100 for exactly 4 cycles,
//    in_ready=0 for first 3, then 0000/out_valid=0; decode_count=1.
//  - Back-to-back: codes 11 then 00 held valid -> 1000 x4 cycles then 0001 x4, out_valid no gap.
//  - Zero flag: in_zero=1,in_code=11 -> out_valid=1, out_onehot=0000 for 4 cycles, count +1.
//  - Reset mid-HOLD: assert rst_n=0 on 2nd hold cycle -> outputs 0 immediately; after release
//    new code 01 -> 0010 with full 4-cycle hold.
//  - Self-check loop: 300 random {in_valid,in_code,in_zero}; model expected one-hot and hold
//    timing, compare each cycle, check one-hot invariant and count saturation (force 260 accepts
//    -> decode_count=255); $stop on first mismatch.

Source files
------------

// File: rtl/prio_codec_pkg.sv
// prio_codec_pkg
//   Definitions shared by both ends of the 4-bit priority encoder link.
//   The encoder and the decoder use the same values:
//     - default index width and the one-hot width derived from it
//     - the encoding of the decoder FSM states
//     - the code value that the encoder emits alongside the zero flag
//   This file has no ports.
package prio_codec_pkg;

  localparam int IN_W_DEFAULT  = 2;
  localparam int OUT_W_DEFAULT = 1 << IN_W_DEFAULT;

  // Width of the hold-time down-counter. It is sized for the largest legal hold time (255).
  localparam int HOLD_TIMER_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // When the source vector is all-zero, the encoder drives this code and raises
  // the zero flag. The decoder ignores the code in that case.
  localparam logic [IN_W_DEFAULT-1:0] ZERO_CODE = '0;

endpackage

// File: rtl/priority_decoder_hold_timer.sv
// hold_timer
//   A loadable down-counter that sets the hold time of each decoded result.
//   A load takes priority over a decrement. The counter never goes below zero.
//   Ports:
//     clk         in   1   rising-edge clock
//     rst_n       in   1   asynchronous active-low reset (count -> 0)
//     load_i      in   1   load load_val_i this cycle
//     load_val_i  in   W   value to load
//     dec_i       in   1   decrement this cycle (ignored at zero)
//     count_o     out  W   current count
//     done_o      out  1   count == 0
module hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == '0);

endmodule

// File: rtl/priority_decoder_hold.sv
// priority_decoder_hold
//   This is the receive side of the priority encoder link. It accepts an encoded index
//   and a zero flag over a valid/ready handshake. It then drives the matching one-hot
//   line for HOLD_CYCLES cycles. It also keeps a saturating count of accepted decodes.
//   Ports:
//     clk           in   1      rising-edge clock
//     rst_n         in   1      asynchronous active-low reset
//     in_valid      in   1      in_code/in_zero valid this cycle
//     in_ready      out  1      a code can be accepted this cycle
//     in_code       in   IN_W   encoded index (all-ones = highest line)
//     in_zero       in   1      source vector was all-zero: decode to no line
//     out_onehot    out  OUT_W  decoded line, held HOLD_CYCLES cycles
//     out_valid     out  1      out_onehot carries a live decode
//     busy          out  1      FSM is in HOLD
//     decode_count  out  CNT_W  accepted transactions, saturating
module priority_decoder_hold
  import prio_codec_pkg::*;
#(
  parameter int IN_W        = IN_W_DEFAULT,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_code,
  input  logic                   in_zero,
  output logic [(1<<IN_W)-1:0]   out_onehot,
  output logic                   out_valid,
  output logic                   busy,
  output logic [CNT_W-1:0]       decode_count
);

  localparam int OUT_W = 1 << IN_W;
  localparam logic [HOLD_TIMER_W-1:0] HOLD_LOAD = HOLD_TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   onehot_q, onehot_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic                    accept;
  logic                    timer_done;
  logic                    timer_dec;
  logic [HOLD_TIMER_W-1:0] timer_count;
  logic [OUT_W-1:0]        decoded;

  hold_timer #(
    .W (HOLD_TIMER_W)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (HOLD_LOAD),
    .dec_i      (timer_dec),
    .count_o    (timer_count),
    .done_o     (timer_done)
  );

  // A new code can be taken while idle, or during the last cycle of a hold.
  // Taking a code in the last hold cycle lets decodes run back-to-back with no gap.
  assign in_ready  = (state_q == ST_IDLE) || timer_done;
  assign accept    = in_valid && in_ready;
  assign timer_dec = (state_q == ST_HOLD) && !timer_done;

  // The zero flag overrides the code. The result therefore holds either no bit or exactly one bit.
  assign decoded = in_zero ? '0 : (OUT_W'(1) << in_code);

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_HOLD;
          onehot_d = decoded;
          valid_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          onehot_d = decoded;
          valid_d  = 1'b1;
        end else if (timer_done) begin
          state_d  = ST_IDLE;
          onehot_d = '0;
          valid_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase

    if (accept && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign out_onehot   = onehot_q;
  assign out_valid    = valid_q;
  assign busy         = (state_q == ST_HOLD);
  assign decode_count = count_q;

endmodule

// File: tb/tb_priority_decoder_hold.sv
// tb_priority_decoder_hold
//   Scoreboard bench for priority_decoder_hold.
//   When the driver's model accepts a decode, it pushes HOLD_CYCLES copies of the
//   expected one-hot word into a queue. After every clock edge, the monitor takes
//   the front entry and expects the DUT to show it with out_valid high. If the
//   queue is empty, the monitor expects the DUT to be idle.
module tb_priority_decoder_hold;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_code = 2'b00;
  logic       in_zero = 1'b0;
  logic [3:0] out_onehot;
  logic       out_valid;
  logic       busy;
  logic [7:0] decode_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] sb[$];
  int         model_cnt = 0;

  priority_decoder_hold #(
    .IN_W        (2),
    .HOLD_CYCLES (H),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .in_zero      (in_zero),
    .out_onehot   (out_onehot),
    .out_valid    (out_valid),
    .busy         (busy),
    .decode_count (decode_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // The driver sends one cycle of stimulus. The model's ready is true when no cycles of an
  // earlier decode remain after the current one.
  task automatic drive(input bit v, input logic [1:0] c, input bit z, output bit acc);
    logic [3:0] e;
    @(negedge clk);
    in_valid = v;
    in_code  = c;
    in_zero  = z;
    acc = v && (sb.size() == 0);
    chk("in_ready", 32'(in_ready), 32'(sb.size() == 0));
    @(posedge clk);
    if (acc) begin
      e = z ? 4'b0000 : 4'(1 << c);
      for (int i = 0; i < H; i++) sb.push_back(e);
      if (model_cnt < 255) model_cnt++;
    end
  endtask

  task automatic send(input logic [1:0] c, input bit z);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      drive(1'b1, c, z, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    model_cnt = 0;
    #1;
    chk("rst_onehot", 32'(out_onehot), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_count", 32'(decode_count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // The monitor checks the outputs 1 time unit after every rising edge. Cycles during reset are skipped.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_valid", 32'(out_valid), 32'(1));
          chk("out_onehot", 32'(out_onehot), 32'(e));
          chk("busy", 32'(busy), 32'(1));
        end else begin
          chk("idle_valid", 32'(out_valid), 32'(0));
          chk("idle_onehot", 32'(out_onehot), 32'(0));
          chk("idle_busy", 32'(busy), 32'(0));
        end
        chk("decode_count", 32'(decode_count), 32'(model_cnt));
        chk("onehot_invariant", 32'($countones(out_onehot) <= 1), 32'(1));
      end
    end
  end

  initial begin
    bit acc;
    int guard;

    do_reset();

    // Single decode of code 2.
    send(2'b10, 1'b0);
    idle(6);

    // Back-to-back decodes, with the source holding valid the whole time.
    send(2'b11, 1'b0);
    send(2'b00, 1'b0);
    idle(6);

    // Zero flag set with code 3: the decode is still counted and marked valid, but no line is set.
    send(2'b11, 1'b1);
    idle(6);

    // Reset asserted during the second hold cycle, then a fresh decode.
    send(2'b10, 1'b0);
    idle(1);
    do_reset();
    send(2'b01, 1'b0);
    idle(6);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), acc);
    end
    idle(6);

    // Push the counter past saturation.
    for (int i = 0; i < 260; i++) begin
      send(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      drive(1'b0, 2'b00, 1'b0, acc);
      guard++;
    end
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'(0));
    idle(2);
    chk("sat_count", 32'(decode_count), 32'(255));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
